// File: rtl/avmm_cfg_sequencer_param.sv
// Avalon-MM configuration sequencer: replays a snapshotted access table for
// NUM_ITER iterations with read-back verify, waitrequest timeout and abort.
module avmm_cfg_sequencer_param #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32,
  parameter int NUM_STEPS   = 3,
  parameter int NUM_ITER    = 24,
  parameter int ADDR_STRIDE = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code,
  output logic [$clog2(NUM_ITER+1)-1:0]     err_iter,
  output logic [$clog2(NUM_STEPS+1)-1:0]    err_step,
  input  logic [NUM_STEPS*ADDR_W-1:0]       step_addr,
  input  logic [NUM_STEPS*DATA_W-1:0]       step_data,
  input  logic [NUM_STEPS*DATA_W-1:0]       step_mask,
  input  logic [NUM_STEPS*(DATA_W/8)-1:0]   step_be,
  input  logic [NUM_STEPS-1:0]              step_is_read,
  input  logic [NUM_STEPS-1:0]              step_ins_iter,
  output logic [ADDR_W-1:0]                 avmm_address,
  output logic [DATA_W-1:0]                 avmm_writedata,
  output logic [DATA_W/8-1:0]               avmm_byteenable,
  output logic                              avmm_write,
  output logic                              avmm_read,
  input  logic [DATA_W-1:0]                 avmm_readdata,
  input  logic                              avmm_waitrequest
);

  localparam int ITER_W = $clog2(NUM_ITER + 1);
  localparam int STEP_W = $clog2(NUM_STEPS + 1);
  localparam int BE_W   = DATA_W / 8;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAIL} state_t;

  state_t state, state_nxt;

  logic [NUM_STEPS*ADDR_W-1:0] tbl_addr;
  logic [NUM_STEPS*DATA_W-1:0] tbl_data;
  logic [NUM_STEPS*DATA_W-1:0] tbl_mask;
  logic [NUM_STEPS*BE_W-1:0]   tbl_be;
  logic [NUM_STEPS-1:0]        tbl_rd;
  logic [NUM_STEPS-1:0]        tbl_ins;

  logic [ITER_W-1:0] iter, iter_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic [TO_W-1:0]   tcnt;
  logic [ADDR_W-1:0] offset;
  logic              abort_pend;

  logic [DATA_W-1:0] cur_raw, cur_wdata, cur_mask;
  logic [ADDR_W-1:0] cur_addr;
  logic [BE_W-1:0]   cur_be;
  logic              cur_read, last_step, last_iter, accept, mismatch, abort_eff;
  logic              load, advance, fail_set;
  logic [1:0]        fail_code;
  logic [ITER_W-1:0] fail_iter;
  logic [STEP_W-1:0] fail_step;

  // current table entry, with the iteration index overwriting the low data bits on writes
  always_comb begin
    cur_raw   = tbl_data[int'(step)*DATA_W +: DATA_W];
    cur_mask  = tbl_mask[int'(step)*DATA_W +: DATA_W];
    cur_be    = tbl_be[int'(step)*BE_W +: BE_W];
    cur_addr  = tbl_addr[int'(step)*ADDR_W +: ADDR_W] + offset;
    cur_read  = tbl_rd[step];
    cur_wdata = cur_raw;
    if (tbl_ins[step] && !cur_read) begin
      cur_wdata[ITER_W-1:0] = iter;
    end else begin
      cur_wdata = cur_raw;
    end
  end

  assign last_step = (step == STEP_W'(NUM_STEPS - 1));
  assign last_iter = (iter == ITER_W'(NUM_ITER - 1));
  assign accept    = (state == S_ACCESS) && !avmm_waitrequest;
  assign mismatch  = cur_read && (|((avmm_readdata ^ cur_raw) & cur_mask));
  assign abort_eff = abort_pend || abort;
  assign step_nxt  = last_step ? STEP_W'(0) : step + STEP_W'(1);
  assign iter_nxt  = last_step ? iter + ITER_W'(1) : iter;

  // next-state and failure classification
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    fail_set  = 1'b0;
    fail_code = 2'd0;
    fail_iter = iter;
    fail_step = step;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ACCESS;
          load      = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (accept) begin
          if (mismatch) begin
            state_nxt = S_FAIL;
            fail_set  = 1'b1;
            fail_code = 2'd2;
          end else if (last_step && last_iter) begin
            state_nxt = S_DONE;
          end else if (abort_eff) begin
            state_nxt = S_FAIL;
            fail_set  = 1'b1;
            fail_code = 2'd3;
            fail_iter = iter_nxt;
            fail_step = step_nxt;
            advance   = 1'b1;
          end else begin
            advance   = 1'b1;
          end
        end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
          state_nxt = S_FAIL;
          fail_set  = 1'b1;
          fail_code = 2'd1;
        end else begin
          state_nxt = S_ACCESS;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_FAIL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state, counters, table snapshot and sticky error status
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      iter       <= '0;
      step       <= '0;
      tcnt       <= '0;
      offset     <= '0;
      abort_pend <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      err_iter   <= '0;
      err_step   <= '0;
      tbl_addr   <= '0;
      tbl_data   <= '0;
      tbl_mask   <= '0;
      tbl_be     <= '0;
      tbl_rd     <= '0;
      tbl_ins    <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        tbl_addr   <= step_addr;
        tbl_data   <= step_data;
        tbl_mask   <= step_mask;
        tbl_be     <= step_be;
        tbl_rd     <= step_is_read;
        tbl_ins    <= step_ins_iter;
        iter       <= '0;
        step       <= '0;
        tcnt       <= '0;
        offset     <= '0;
        abort_pend <= abort;
        error      <= 1'b0;
        err_code   <= 2'd0;
        err_iter   <= '0;
        err_step   <= '0;
      end else if (state == S_ACCESS) begin
        if (accept) begin
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + TO_W'(1);
        end
        if (advance) begin
          step <= step_nxt;
          iter <= iter_nxt;
          if (last_step) begin
            offset <= offset + ADDR_W'(ADDR_STRIDE);
          end else begin
            offset <= offset;
          end
        end else begin
          step <= step;
        end
        if (abort) begin
          abort_pend <= 1'b1;
        end else begin
          abort_pend <= abort_pend;
        end
        if (fail_set) begin
          error    <= 1'b1;
          err_code <= fail_code;
          err_iter <= fail_iter;
          err_step <= fail_step;
        end else begin
          error    <= error;
        end
      end else begin
        tcnt       <= '0;
        abort_pend <= 1'b0;
      end
    end
  end

  assign busy            = (state == S_ACCESS);
  assign done            = (state == S_DONE);
  assign avmm_write      = (state == S_ACCESS) && !cur_read;
  assign avmm_read       = (state == S_ACCESS) && cur_read;
  assign avmm_address    = (state == S_ACCESS) ? cur_addr  : '0;
  assign avmm_writedata  = (state == S_ACCESS) ? cur_wdata : '0;
  assign avmm_byteenable = (state == S_ACCESS) ? cur_be    : '0;

endmodule

// File: tb/tb_avmm_cfg_sequencer_param.sv
// Directed bench for avmm_cfg_sequencer_param: scenario table plus
// hand-written timeout, reset and idle-abort sequences.
module tb_avmm_cfg_sequencer_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [4:0]  err_iter;
  logic [1:0]  err_step;
  logic [50:0] step_addr = '0;
  logic [95:0] step_data = '0;
  logic [95:0] step_mask = '0;
  logic [11:0] step_be = '0;
  logic [2:0]  step_is_read = '0;
  logic [2:0]  step_ins_iter = '0;
  logic [16:0] avmm_address;
  logic [31:0] avmm_writedata;
  logic [3:0]  avmm_byteenable;
  logic        avmm_write, avmm_read;
  logic [31:0] avmm_readdata = '0;
  logic        avmm_waitrequest = 1'b0;

  int total = 0;
  int bad = 0;

  avmm_cfg_sequencer_param #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .err_iter(err_iter), .err_step(err_step),
    .step_addr(step_addr), .step_data(step_data), .step_mask(step_mask),
    .step_be(step_be), .step_is_read(step_is_read), .step_ins_iter(step_ins_iter),
    .avmm_address(avmm_address), .avmm_writedata(avmm_writedata),
    .avmm_byteenable(avmm_byteenable), .avmm_write(avmm_write), .avmm_read(avmm_read),
    .avmm_readdata(avmm_readdata), .avmm_waitrequest(avmm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wait_n;
    bit rd1;
    int bad_iter;
    int abort_iter;
    int abort_step;
    bit abort_at_start;
    bit exp_done;
    int exp_code;
    int exp_iter;
    int exp_step;
    int exp_acc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load_table(input bit rd1);
    step_addr     = {17'h00300, 17'h00200, 17'h00100};
    step_data     = {32'h0000_0033, 32'hA5A5_0000, 32'h1234_56FF};
    step_mask     = {32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000};
    step_be       = {4'hC, 4'h3, 4'hF};
    step_is_read  = {1'b0, rd1, 1'b0};
    step_ins_iter = 3'b001;
  endtask

  task automatic check_idle_bus(input string tag);
    chk({tag, "_write"}, avmm_write, 1'b0);
    chk({tag, "_read"}, avmm_read, 1'b0);
    chk({tag, "_addr"}, avmm_address, 17'h0);
    chk({tag, "_wdata"}, avmm_writedata, 32'h0);
    chk({tag, "_be"}, avmm_byteenable, 4'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e_it, e_st, waited, acc, act_cyc;
    bit fin, exp_rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    load_table(v.rd1);
    @(negedge clk);
    start = 1'b1;
    abort = v.abort_at_start;
    avmm_waitrequest = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("error_cleared", error, 1'b0);
    e_it = 0; e_st = 0; waited = 0; acc = 0; act_cyc = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      abort = 1'b0;
      if (done || error) begin
        fin = 1'b1;
      end else if (avmm_write || avmm_read) begin
        act_cyc++;
        exp_rd = v.rd1 && (e_st == 1);
        exp_be = (e_st == 0) ? 4'hF : (e_st == 1) ? 4'h3 : 4'hC;
        exp_wd = (e_st == 0) ? (32'h1234_56E0 | 32'(e_it)) :
                 (e_st == 1) ? 32'hA5A5_0000 : 32'h0000_0033;
        chk("cmd_read", avmm_read, exp_rd);
        chk("cmd_write", avmm_write, !exp_rd);
        chk("addr", avmm_address, 17'(32'h100 * (e_st + 1) + e_it));
        chk("be", avmm_byteenable, exp_be);
        if (!exp_rd) chk("wdata", avmm_writedata, exp_wd);
        if (waited == 0 && e_it == v.abort_iter && e_st == v.abort_step) abort = 1'b1;
        if (waited < v.wait_n) begin
          avmm_waitrequest = 1'b1;
          waited++;
        end else begin
          avmm_waitrequest = 1'b0;
          avmm_readdata = (e_it == v.bad_iter) ? 32'hA4A5_0000 : 32'hA5A5_1234;
          waited = 0;
          acc++;
          if (e_st == 2) begin e_st = 0; e_it++; end else e_st++;
        end
      end else begin
        chk("cmd_present", {avmm_write, avmm_read}, 2'b01);
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    abort = 1'b0;
    avmm_waitrequest = 1'b0;
    chk("finished_in_budget", fin, 1'b1);
    $display("vector %0d: %0d accesses", idx, acc);
    chk("done", done, v.exp_done);
    chk("error", error, !v.exp_done);
    chk("err_code", err_code, v.exp_code);
    chk("err_iter", err_iter, v.exp_iter);
    chk("err_step", err_step, v.exp_step);
    chk("access_count", acc, v.exp_acc);
    chk("access_cycles", act_cyc, v.exp_acc * (v.wait_n + 1));
    chk("busy_end", busy, 1'b0);
    check_idle_bus("end");
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("error_sticky", error, !v.exp_done);
    check_idle_bus("after");
  endtask

  vec_t vecs[8];

  initial begin
    int hi_cnt;
    vecs[0] = '{0, 1'b0, -1, -1, -1, 1'b0, 1'b1, 0, 0, 0, 72};
    vecs[1] = '{3, 1'b0, -1, -1, -1, 1'b0, 1'b1, 0, 0, 0, 72};
    vecs[2] = '{0, 1'b1,  5, -1, -1, 1'b0, 1'b0, 2, 5, 1, 17};
    vecs[3] = '{2, 1'b0, -1,  2,  1, 1'b0, 1'b0, 3, 2, 2, 8};
    vecs[4] = '{0, 1'b0, -1, 23,  2, 1'b0, 1'b1, 0, 0, 0, 72};
    vecs[5] = '{0, 1'b1,  3,  3,  1, 1'b0, 1'b0, 2, 3, 1, 11};
    vecs[6] = '{1, 1'b1, -1, -1, -1, 1'b0, 1'b1, 0, 0, 0, 72};
    vecs[7] = '{0, 1'b0, -1, -1, -1, 1'b1, 1'b0, 3, 0, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    check_idle_bus("rst");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // waitrequest stuck high on the first access
    load_table(1'b0);
    @(negedge clk);
    start = 1'b1;
    avmm_waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 20 && !error; c++) begin
      if (avmm_write) hi_cnt++;
      @(negedge clk);
    end
    chk("to_write_cycles", hi_cnt, 4);
    chk("to_error", error, 1'b1);
    chk("to_err_code", err_code, 2'd1);
    chk("to_err_iter", err_iter, 5'd0);
    chk("to_err_step", err_step, 2'd0);
    chk("to_busy", busy, 1'b0);
    chk("to_write_low", avmm_write, 1'b0);

    // restart clears the stale error, then reset mid-write
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rs_error_cleared", error, 1'b0);
    chk("rs_err_code_cleared", err_code, 2'd0);
    chk("rs_addr", avmm_address, 17'h00100);
    chk("rs_write", avmm_write, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    avmm_waitrequest = 1'b0;
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", done, 1'b0);
    chk("rs_error", error, 1'b0);
    check_idle_bus("rs");

    // abort in idle is ignored; the next run starts from iter 0 step 0
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    run_vec(vecs[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avmm_cfg_sequencer_param.md
Name: avmm_cfg_sequencer_param

Overview:
Parametrised Avalon-MM configuration sequencer. It replays a table of NUM_STEPS accesses (write, or read-and-compare) for NUM_ITER loop iterations on one Avalon-MM master port. The address advances by a stride per iteration, and the iteration index can be optionally inserted into the write data. It sits between top-level bring-up control and a peripheral configuration port, and adds read-back verify, a waitrequest timeout and abort.

Parameters:
ADDR_W, 17, Avalon address width
DATA_W, 32, Avalon data width (multiple of 8)
NUM_STEPS, 3, table entries per iteration (>=1)
NUM_ITER, 24, loop iterations (>=1)
ADDR_STRIDE, 1, address increment per iteration (unsigned, wraps modulo 2^ADDR_W)
TIMEOUT, 255, maximum consecutive waitrequest cycles per access (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin sequence; sampled only in IDLE
abort  in  1  stop at the next access boundary
busy  out  1  high from the cycle after start until done or error
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky until the next accepted start
err_code  out  2  0 = none, 1 = timeout, 2 = compare mismatch, 3 = aborted
err_iter  out  $clog2(NUM_ITER+1)  iteration index at failure
err_step  out  $clog2(NUM_STEPS+1)  step index at failure
step_addr  in  NUM_STEPS*ADDR_W  per-step base address
step_data  in  NUM_STEPS*DATA_W  write data, or read expected value
step_mask  in  NUM_STEPS*DATA_W  read compare mask (1 = compare bit)
step_be  in  NUM_STEPS*(DATA_W/8)  byteenable
step_is_read  in  NUM_STEPS  1 = read-compare, 0 = write
step_ins_iter  in  NUM_STEPS  1 = replace data bits [ITER_W-1:0] with the iteration index (writes only)
avmm_address  out  ADDR_W
avmm_writedata  out  DATA_W
avmm_byteenable  out  DATA_W/8
avmm_write  out  1
avmm_read  out  1
avmm_readdata  in  DATA_W
avmm_waitrequest  in  1

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; iteration, step and timeout counters are 0. Reset during an access drops avmm_write/avmm_read on the next edge. No completion is reported.
- FSM states: IDLE, ACCESS, DONE, FAIL.
- IDLE: start=1 loads the table snapshot (table inputs are registered at start and ignored afterwards). It clears error/err_*, sets iter=0 and step=0, and moves to ACCESS. avmm_write or avmm_read is asserted in the next cycle (1-cycle start latency).
- ACCESS:
  - avmm_address = step_addr[step] + iter*ADDR_STRIDE, truncated to ADDR_W.
  - Command, address, data and byteenable are held stable while avmm_waitrequest=1.
  - The access is accepted in the cycle avmm_waitrequest=0. For reads, avmm_readdata is sampled in that same cycle (no pipelined reads).
- Read-compare: a mismatch is any bit set in ((readdata ^ step_data) & step_mask). Mismatch → FAIL with err_code=2.
- After acceptance:
  - If this was the last step of the last iteration → DONE.
  - Otherwise step increments (wrapping to 0 with iter+1), and the next access is driven in the immediately following cycle, with no bubble.
  - With waitrequest=0 throughout, the accesses occupy NUM_STEPS*NUM_ITER consecutive cycles.
- Timeout:
  - The counter increments each cycle with waitrequest=1 and clears on acceptance.
  - Reaching TIMEOUT → FAIL with err_code=1, and the command is deasserted.
  - The command therefore remains asserted for exactly TIMEOUT waitrequest cycles.
- Abort:
  - Latched when seen in ACCESS. The in-flight access is never dropped (Avalon hold rule) and completes normally.
  - At its acceptance, go to FAIL with err_code=3; err_iter/err_step give the next unexecuted position.
  - If the aborted access was the final one, DONE takes priority and the abort is discarded.
  - abort in IDLE is ignored.
  - If start and abort are both high in IDLE, start wins and abort is latched (only one access executes).
- DONE: done=1 for one cycle, busy drops, then return to IDLE.
- FAIL: error=1, err_* are registered, busy drops, then return to IDLE. error holds until the next start.
- Simultaneous events: a mismatch and an abort on the same acceptance report mismatch (code 2).
- start while busy is ignored.
- avmm_read and avmm_write are never high together.
- Outside ACCESS, avmm_address, avmm_writedata and avmm_byteenable are 0.
- ITER_W = $clog2(NUM_ITER+1). Inserted iteration bits overwrite data; they are not ORed into it.

Test Plan:
1. Defaults, 3 writes (0x100/0x200/0x300, step_ins_iter=001), waitrequest=0, start pulse → 72 writes in consecutive cycles starting 1 cycle after start. Step-0 data low 5 bits = 0..23; addresses 0x100..0x117; done pulse after the 72nd; error=0.
2. Waitrequest held 3 cycles on every access → each command held 4 cycles with stable address/data; done after 288 access cycles.
3. Step 1 a read, expected 0xA5A5_0000, mask 0xFFFF_0000; readdata 0xA5A5_1234 passes. Readdata 0xA4A5_0000 at iter 5 → error=1, err_code=2, err_iter=5, err_step=1, no further accesses.
4. TIMEOUT=4, waitrequest stuck at 1 on the first access → avmm_write high exactly 4 cycles, then err_code=1, err_iter=0, err_step=0, busy=0.
5. abort at iter 2 step 1 with waitrequest=1 for 2 cycles → that write completes, then err_code=3, err_iter=2, err_step=2; an abort on the final access → done=1, error=0.
6. rst asserted mid-write with waitrequest=1 → next cycle all outputs 0. A new start then restarts from iter 0, step 0, and clears the stale error.
